vcve2_vrf_responder: RTL
========================

Name: vcve2_vrf_responder

Overview:
- Memory-side responder for the vector register file (VRF) address window.
- Accepts word requests on an OBI-style req/gnt/rvalid interface from the vector load/store path. That path is driven by the VRF address generator, whose addresses are {VrfBase, reg[4:0], word[1:0], 2'b00}.
- Stores 32 vector registers x 4 words (VLEN=128), i.e. 128 words of 32 bits.
- Performs byte-enabled writes and fixed-latency reads, and returns an error for out-of-window or misaligned addresses.
- After reset, a sequential init engine zeroes the whole array before it grants any request.

Parameters:
- AddrWidth, 32, request address width; must be >= 10.
- VrfBase, vcve2_pkg::VRF_START_ADDR, value that addr_i[AddrWidth-1:9] must equal for a hit; width AddrWidth-9.
- ReadLatency, 1, cycles from the accept cycle to rvalid_o; legal values are 1 and 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset: asynchronous, active-low.
- req_i  in  1  request valid.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables, used for writes only.
- addr_i  in  AddrWidth  byte address.
- wdata_i  in  32  write data.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data; 0 for writes and errors.
- err_o  out  1  response error; qualified by rvalid_o.
- init_done_o  out  1  array zeroing complete.

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, init_done_o=0. FSM=INIT, init_cnt=0, response pipeline cleared.
- FSM, state INIT:
  - Each cycle, word[init_cnt] is written to 0 and init_cnt increments (7 bits).
  - When init_cnt==127 is written, the FSM goes to RUN.
  - gnt_o=0 throughout INIT; req_i is ignored and no response is generated.
  - INIT lasts exactly 128 cycles after reset release.
- FSM, state RUN:
  - init_done_o=1 (registered, high from the first RUN cycle).
  - gnt_o=req_i, combinational; there is no back-pressure.
  - Accept = req_i & gnt_o. At most one accept per cycle; back-to-back accepts are allowed every cycle.
  - RUN never returns to INIT except via reset.
- Decode:
  - hit = (addr_i[AddrWidth-1:9]==VrfBase) & (addr_i[1:0]==0).
  - Word index = addr_i[8:2]: reg = addr_i[8:4], word = addr_i[3:2].
- Write accept with hit: for each i where be_i[i]=1, byte i of the word is replaced by wdata_i[8i+7:8i] at the accept clock edge. Disabled bytes are unchanged. be_i=0 is a legal no-op write that still gets a response.
- Read accept with hit: data is the word's value at the accept edge, i.e. it includes all writes accepted in earlier cycles. It is captured at accept; a later write before rvalid does not alter it.
- Miss or misaligned (read or write): no storage change; response has err_o=1, rdata_o=0.
- Response:
  - Every accepted request produces exactly one response, in order, with rvalid_o=1 for one cycle exactly ReadLatency cycles after the accept cycle.
  - Writes respond with rdata_o=0, err_o=0 on hit.
  - When rvalid_o=0: rdata_o=0, err_o=0.
  - The response shift register is ReadLatency deep and holds {valid, err, data}.
- Read and write of the same word in the same cycle cannot occur (single port, one accept per cycle). A write accepted in cycle N is visible to a read accepted in cycle N+1.
- Reset mid-operation: in-flight responses are discarded (rvalid_o=0 immediately), storage contents are don't-care, and INIT restarts from word 0.
- Latency: gnt is combinational (0 cycles); response comes ReadLatency cycles after accept.

Test Plan:
- Init: release reset, hold req_i=1 -> gnt_o=0 for 128 cycles, init_done_o=1 on cycle 128, then gnt_o=1; reads of reg0 word0 and reg31 word3 return 0x00000000, err_o=0.
- Full write/read: write 0xDEADBEEF, be=4'hF, to {VrfBase, 5'd5, 2'd2, 2'b00} -> write response err=0, rdata=0; read of the same address -> rdata_o=0xDEADBEEF, with rvalid exactly ReadLatency cycles after gnt.
- Byte enables: then write 0x12345678 with be=4'b0011 to the same word -> readback 0xDEAD5678; be=4'b0000 write -> readback unchanged.
- Errors:
  - Address with upper bits != VrfBase -> err_o=1, rdata_o=0.
  - addr_i[1:0]=2'b10 -> err_o=1.
  - Neither changes the previously written word.
- Streaming, for ReadLatency=1 and 2: 4 back-to-back reads of reg7 words 0..3 (prewritten with 0x70..0x73) -> 4 consecutive rvalid cycles with 0x70,0x71,0x72,0x73 in order. A read followed next cycle by a write to the same word -> the read returns the old value.
- Mid-stream reset: assert rst_ni low with 2 responses in flight -> rvalid_o=0 immediately, no stale response after release, init_done_o=0 and gnt_o=0 for 128 cycles, then all words read 0.

Source files
------------

// File: rtl/vcve2_vrf_responder.sv
// ---------------------------------------------------------------------------
// vcve2_pkg / vcve2_vrf_responder
//
// Memory-side responder for the vector register file address window.
// The VRF is 32 registers x 4 words x 32 bits (128 words). The responder
// takes OBI-style word requests and performs byte-enabled writes and
// fixed-latency reads. Out-of-window or misaligned requests get an error
// response. After reset, an init engine zeroes every word before any
// request is granted.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   req_i, we_i     request valid, write (1) / read (0)
//   be_i            byte enables (writes only)
//   addr_i          byte address {VrfBase, reg[4:0], word[1:0], 2'b00}
//   wdata_i         write data
//   gnt_o           combinational grant (req_i while running)
//   rvalid_o        response valid, ReadLatency cycles after the accept
//   rdata_o         read data (0 for writes, errors and idle cycles)
//   err_o           response error, qualified by rvalid_o
//   init_done_o     array zeroing complete
// ---------------------------------------------------------------------------

package vcve2_pkg;

    // Upper address bits [31:9] of the VRF window (0x1A11_0000).
    localparam logic [22:0] VRF_START_ADDR = 23'h0D0880;

    // One entry of the response pipeline.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } vrf_rsp_t;

endpackage

module vcve2_vrf_responder #(
    parameter int unsigned           AddrWidth   = 32,
    parameter logic [AddrWidth-10:0] VrfBase     = (AddrWidth-9)'(vcve2_pkg::VRF_START_ADDR),
    parameter int unsigned           ReadLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic                 init_done_o
);
    import vcve2_pkg::*;

    localparam int unsigned NumWords  = 128;
    localparam int unsigned IdxWidth  = 7;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned NumBytes  = 4;

    typedef enum logic [0:0] {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    vrf_rsp_t              rsp_q [ReadLatency];
    vrf_rsp_t              rsp_d [ReadLatency];
    vrf_rsp_t              rsp_new;

    logic [DataWidth-1:0]  mem_q [NumWords];
    logic                  mem_we;
    logic [NumBytes-1:0]   mem_be;
    logic [IdxWidth-1:0]   mem_widx;
    logic [DataWidth-1:0]  mem_wdata;

    logic                  hit;
    logic                  accept;
    logic [IdxWidth-1:0]   word_idx;

    // Address decode: window match plus word alignment.
    assign word_idx = addr_i[8:2];
    assign hit      = (addr_i[AddrWidth-1:9] == VrfBase) && (addr_i[1:0] == 2'b00);

    // No back-pressure once running; accept is simply the grant.
    assign gnt_o  = req_i && (state_q == StRun);
    assign accept = gnt_o;

    // Next-state, storage write port and new response entry.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_widx   = init_cnt_q;
        mem_wdata  = '0;
        rsp_new    = '0;

        case (state_q)
            StInit: begin
                mem_we     = 1'b1;
                mem_be     = '1;
                mem_widx   = init_cnt_q;
                mem_wdata  = '0;
                init_cnt_d = init_cnt_q + IdxWidth'(1);
                if (init_cnt_q == IdxWidth'(NumWords - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    rsp_new.valid = 1'b1;
                    rsp_new.err   = ~hit;
                    if (hit) begin
                        if (we_i) begin
                            mem_we    = 1'b1;
                            mem_be    = be_i;
                            mem_widx  = word_idx;
                            mem_wdata = wdata_i;
                        end else begin
                            // Captured now, so later writes cannot alter it.
                            rsp_new.data = mem_q[word_idx];
                        end
                    end
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // init_done tracks the state register exactly: high from the first RUN cycle.
    assign init_done_d = (state_d == StRun);

    // Response shift register, ReadLatency entries deep.
    always_comb begin
        rsp_d[0] = rsp_new;
        for (int unsigned i = 1; i < ReadLatency; i++) begin
            rsp_d[i] = rsp_q[i-1];
        end
    end

    // Control and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            for (int unsigned i = 0; i < ReadLatency; i++) begin
                rsp_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            for (int unsigned i = 0; i < ReadLatency; i++) begin
                rsp_q[i] <= rsp_d[i];
            end
        end
    end

    // Storage array; contents are don't-care across reset, so no reset here.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rvalid_o    = rsp_q[ReadLatency-1].valid;
    assign err_o       = rsp_q[ReadLatency-1].err;
    assign rdata_o     = rsp_q[ReadLatency-1].data;
    assign init_done_o = init_done_q;

endmodule
